rf_wb_ctrl: RTL and testbench

//  Write-back controller for the 32x32 register file (x0 hard-wired zero, active-low write enable).

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_scoreboard.sv | 60 ++++++
 rtl/rf_wb_ctrl.sv | 85 ++++++++
 tb/tb_rf_wb_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and sizes for the register-file write-back path.
package rf_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    // Producer port numbers, also the encoding of the round-robin pointer
    localparam logic PORT_ALU = 1'b0;
    localparam logic PORT_LSU = 1'b1;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: tracks registers with an outstanding write,
// gates decode on WAW, and flags RAW hazards or bypass hits for rs1/rs2.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic            wr_valid,
    input  logic [AW-1:0]   wr_rd,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            hz_rs1,
    output logic            hz_rs2,
    output logic            byp_rs1,
    output logic            byp_rs2,
    output logic [NREG-1:0] pend
);

    logic            set_en;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    // A register may be re-issued in the very cycle its previous write lands
    assign issue_ready = (issue_rd == '0) || !pend[issue_rd]
                      || (wr_valid && (wr_rd == issue_rd));

    // x0 never becomes pending, so it can never hazard
    assign set_en = issue_valid && issue_ready && (issue_rd != '0);

    // Build one-hot set/clear masks for this cycle
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        set_mask = '0;
        clr_mask = '0;
        if (set_en)
            set_mask[issue_rd] = 1'b1;
        if (wr_valid)
            clr_mask[wr_rd] = 1'b1;
    end

    // Pending mask update; OR-ing the set after the clear makes set win on a tie
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the mask is 32 plain flops, not a RAM, so it is safe and cheap to reset.
        if (reset)
            pend <= '0;
        else
            // NOTE: non-blocking so every flop samples pre-edge values regardless of order.
            pend <= (pend & ~clr_mask) | set_mask;
    end

    // The register landing this cycle is visible on rf_wdata, so it bypasses instead of stalling
    assign byp_rs1 = wr_valid && (wr_rd == rs1) && (rs1 != '0);
    assign byp_rs2 = wr_valid && (wr_rd == rs2) && (rs2 != '0);
    assign hz_rs1  = pend[rs1] && !byp_rs1;
    assign hz_rs2  = pend[rs2] && !byp_rs2;

endmodule

// File: rtl/rf_wb_ctrl.sv
// Write-back controller: round-robin arbitration of ALU and LSU onto the
// single RF write port, registered write outputs, and the pending scoreboard.
module rf_wb_ctrl
    import rf_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_ready,
    input  logic            req0_valid,
    input  logic [AW-1:0]   req0_rd,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [AW-1:0]   req1_rd,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    output logic [AW-1:0]   rf_rd,
    output logic [XLEN-1:0] rf_wdata,
    output logic            rf_wen_n,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic            hz_rs1,
    output logic            hz_rs2,
    output logic            byp_rs1,
    output logic            byp_rs2
);

    logic            rr_ptr;   // port preferred when both request
    logic            grant0;
    logic            grant1;
    wb_req_t         win;
    logic [NREG-1:0] pend;

    // Lone requester always wins; on contention the pointer decides
    assign grant0 = req0_valid && (!req1_valid || (rr_ptr == PORT_ALU));
    assign grant1 = req1_valid && (!req0_valid || (rr_ptr == PORT_LSU));
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign win = grant1 ? wb_req_t'{rd: req1_rd, data: req1_data}
                        : wb_req_t'{rd: req0_rd, data: req0_data};

    // Register the winning request onto the RF port and advance the pointer past the winner
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_wen_n <= 1'b1;
            rf_rd    <= '0;
            rf_wdata <= '0;
            rr_ptr   <= PORT_ALU;
        end else if (grant0 || grant1) begin
            rf_rd    <= win.rd;
            rf_wdata <= win.data;
            rf_wen_n <= (win.rd == '0);   // x0 writes are swallowed here
            rr_ptr   <= grant0 ? PORT_LSU : PORT_ALU;
        end else begin
            rf_wen_n <= 1'b1;
        end
    end

    rf_scoreboard u_sb (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .wr_valid    (!rf_wen_n),
        .wr_rd       (rf_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .hz_rs1      (hz_rs1),
        .hz_rs2      (hz_rs2),
        .byp_rs1     (byp_rs1),
        .byp_rs2     (byp_rs2),
        .pend        (pend)
    );

    // A producer writing back a register decode never marked pending is a protocol error
    a_req0_pending: assert property (@(posedge clk) disable iff (reset)
        (grant0 && (req0_rd != '0)) |-> pend[req0_rd]);
    a_req1_pending: assert property (@(posedge clk) disable iff (reset)
        (grant1 && (req1_rd != '0)) |-> pend[req1_rd]);

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed bench for rf_wb_ctrl with hand-computed expected values.
module tb_rf_wb_ctrl;
    import rf_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            issue_ready;
    logic            req0_valid;
    logic [AW-1:0]   req0_rd;
    logic [XLEN-1:0] req0_data;
    logic            req0_ready;
    logic            req1_valid;
    logic [AW-1:0]   req1_rd;
    logic [XLEN-1:0] req1_data;
    logic            req1_ready;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic            rf_wen_n;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic            hz_rs1;
    logic            hz_rs2;
    logic            byp_rs1;
    logic            byp_rs2;

    int n_tests = 0;
    int n_fail  = 0;

    rf_wb_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .req0_valid  (req0_valid),
        .req0_rd     (req0_rd),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_rd     (req1_rd),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .rf_rd       (rf_rd),
        .rf_wdata    (rf_wdata),
        .rf_wen_n    (rf_wen_n),
        .rs1         (rs1),
        .rs2         (rs2),
        .hz_rs1      (hz_rs1),
        .hz_rs2      (hz_rs2),
        .byp_rs1     (byp_rs1),
        .byp_rs2     (byp_rs2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Step past the next rising edge; registered outputs are settled 1 ns later
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Port 0 items then port 1 items for the contention test
    logic [AW-1:0]   p0_rd   [3] = '{5'd12, 5'd14, 5'd16};
    logic [XLEN-1:0] p0_data [3] = '{32'hA000_0012, 32'hA000_0014, 32'hA000_0016};
    logic [AW-1:0]   p1_rd   [2] = '{5'd13, 5'd15};
    logic [XLEN-1:0] p1_data [2] = '{32'hB000_0013, 32'hB000_0015};

    initial begin
        int i0;
        int i1;
        reset = 1'b1;
        issue_valid = 1'b0; issue_rd = '0;
        req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
        req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
        rs1 = '0; rs2 = '0;
        tick();
        tick();
        check("rst_wen_n", 32'(rf_wen_n), 32'd1);
        check("rst_rf_rd", 32'(rf_rd), 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        reset = 1'b0;

        // ---- 1: reset asserted while a write is on the port
        issue_valid = 1'b1; issue_rd = 5'd3;
        tick();
        issue_rd = 5'd4;
        req0_valid = 1'b1; req0_rd = 5'd3; req0_data = 32'h0000_00AA;
        tick();
        issue_valid = 1'b0; req0_valid = 1'b0; rs1 = 5'd4; rs2 = 5'd3;
        #1;
        check("t1_pre_wen_n", 32'(rf_wen_n), 32'd0);
        check("t1_pre_hz_rs1", 32'(hz_rs1), 32'd1);
        reset = 1'b1;
        #1;
        check("t1_wen_n", 32'(rf_wen_n), 32'd1);
        check("t1_rf_rd", 32'(rf_rd), 32'd0);
        check("t1_wdata", rf_wdata, 32'd0);
        check("t1_hz_rs1", 32'(hz_rs1), 32'd0);
        check("t1_hz_rs2", 32'(hz_rs2), 32'd0);
        tick();
        reset = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd10;
        tick();
        issue_rd = 5'd11;
        tick();
        issue_valid = 1'b0;
        req0_valid = 1'b1; req0_rd = 5'd10; req0_data = 32'h1111_0010;
        req1_valid = 1'b1; req1_rd = 5'd11; req1_data = 32'h2222_0011;
        #1;
        check("t1_first_req0", 32'(req0_ready), 32'd1);
        check("t1_first_req1", 32'(req1_ready), 32'd0);
        tick();
        req0_valid = 1'b0;
        #1;
        check("t1_rd10", 32'(rf_rd), 32'd10);
        check("t1_req1_alone", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        check("t1_rd11", 32'(rf_rd), 32'd11);
        check("t1_wd11", rf_wdata, 32'h2222_0011);
        tick();
        check("t1_idle_wen_n", 32'(rf_wen_n), 32'd1);

        // ---- 2: single ALU write of x5
        issue_valid = 1'b1; issue_rd = 5'd5;
        #1;
        check("t2_issue_ready", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0;
        req0_valid = 1'b1; req0_rd = 5'd5; req0_data = 32'hDEAD_BEEF; rs1 = 5'd5;
        #1;
        check("t2_req0_ready", 32'(req0_ready), 32'd1);
        check("t2_hz_pending", 32'(hz_rs1), 32'd1);
        tick();
        req0_valid = 1'b0;
        #1;
        check("t2_wen_n", 32'(rf_wen_n), 32'd0);
        check("t2_rf_rd", 32'(rf_rd), 32'd5);
        check("t2_wdata", rf_wdata, 32'hDEAD_BEEF);
        check("t2_byp_rs1", 32'(byp_rs1), 32'd1);
        tick();
        check("t2_wen_n_after", 32'(rf_wen_n), 32'd1);
        check("t2_pend_clear", 32'(hz_rs1), 32'd0);

        // ---- 6: x0 is never pending; x0 write accepted but suppressed, pointer moves to port 0
        issue_valid = 1'b1; issue_rd = 5'd0;
        #1;
        check("t6_issue_x0", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0; rs1 = 5'd0;
        req1_valid = 1'b1; req1_rd = 5'd0; req1_data = 32'h0000_1234;
        #1;
        check("t6_hz_x0", 32'(hz_rs1), 32'd0);
        check("t6_req1_ready", 32'(req1_ready), 32'd1);
        tick();
        req1_valid = 1'b0;
        check("t6_wen_n", 32'(rf_wen_n), 32'd1);
        check("t6_rf_rd", 32'(rf_rd), 32'd0);
        check("t6_wdata", rf_wdata, 32'h0000_1234);

        // ---- 3: both ports contend for four cycles, grants alternate 0,1,0,1
        issue_valid = 1'b1;
        foreach (p0_rd[k]) begin issue_rd = p0_rd[k]; tick(); end
        foreach (p1_rd[k]) begin issue_rd = p1_rd[k]; tick(); end
        issue_valid = 1'b0;
        i0 = 0; i1 = 0;
        for (int k = 0; k < 4; k++) begin
            req0_valid = 1'b1; req0_rd = p0_rd[i0]; req0_data = p0_data[i0];
            req1_valid = 1'b1; req1_rd = p1_rd[i1]; req1_data = p1_data[i1];
            #1;
            check($sformatf("t3_req0_ready_%0d", k), 32'(req0_ready), 32'(k % 2 == 0));
            check($sformatf("t3_req1_ready_%0d", k), 32'(req1_ready), 32'(k % 2 == 1));
            tick();
            check($sformatf("t3_wen_n_%0d", k), 32'(rf_wen_n), 32'd0);
            if (k % 2 == 0) begin
                check($sformatf("t3_rd_%0d", k), 32'(rf_rd), 32'(p0_rd[i0]));
                check($sformatf("t3_wd_%0d", k), rf_wdata, p0_data[i0]);
                i0++;
            end else begin
                check($sformatf("t3_rd_%0d", k), 32'(rf_rd), 32'(p1_rd[i1]));
                check($sformatf("t3_wd_%0d", k), rf_wdata, p1_data[i1]);
                i1++;
            end
        end
        req1_valid = 1'b0;
        req0_rd = p0_rd[2]; req0_data = p0_data[2];
        #1;
        check("t3_tail_ready", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        check("t3_tail_rd", 32'(rf_rd), 32'd16);
        tick();

        // ---- 4: hazard on x7 turns into a bypass while x7 is landing; rs2=x0 stays quiet
        issue_valid = 1'b1; issue_rd = 5'd7;
        tick();
        issue_valid = 1'b0; rs1 = 5'd7; rs2 = 5'd0;
        #1;
        check("t4_hz_rs1", 32'(hz_rs1), 32'd1);
        check("t4_byp_rs1", 32'(byp_rs1), 32'd0);
        req0_valid = 1'b1; req0_rd = 5'd7; req0_data = 32'h0000_0077;
        tick();
        req0_valid = 1'b0;
        #1;
        check("t4_byp_rs1_land", 32'(byp_rs1), 32'd1);
        check("t4_hz_rs1_land", 32'(hz_rs1), 32'd0);
        check("t4_hz_rs2", 32'(hz_rs2), 32'd0);
        check("t4_byp_rs2", 32'(byp_rs2), 32'd0);
        tick();
        check("t4_hz_rs1_done", 32'(hz_rs1), 32'd0);
        check("t4_byp_rs1_done", 32'(byp_rs1), 32'd0);

        // ---- 5: WAW hold on x9, then re-issue in the cycle the write lands (set wins)
        issue_valid = 1'b1; issue_rd = 5'd9;
        tick();
        #1;
        check("t5_waw_hold", 32'(issue_ready), 32'd0);
        req0_valid = 1'b1; req0_rd = 5'd9; req0_data = 32'h0000_0099;
        #1;
        check("t5_req0_ready", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        #1;
        check("t5_land_rd", 32'(rf_rd), 32'd9);
        check("t5_land_ready", 32'(issue_ready), 32'd1);
        tick();
        issue_valid = 1'b0; rs1 = 5'd9;
        #1;
        check("t5_wen_n", 32'(rf_wen_n), 32'd1);
        check("t5_set_wins_hz", 32'(hz_rs1), 32'd1);
        check("t5_set_wins_rdy", 32'(issue_ready), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
